uart_rx_ctrl: RTL and testbench
===============================

UART_RX_CTRL -- requirements
Module: uart_rx_ctrl

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 8, data bits per frame (legal values 5..16).
REQ-002 The block SHALL have parameter CLKS_PER_BIT, default 16, clk cycles per serial bit (legal values >= 4).
REQ-003 clk  input  1  sole clock; all flops rise-edge.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 rx  input  1  asynchronous serial line, idle high.
REQ-006 shift_en  output  1  one-cycle pulse to the SIPO register per sampled data bit.
REQ-007 serial_out  output  1  sampled data bit, drives the SIPO serial input; valid while shift_en=1.
REQ-008 parallel_in  input  DATA_WIDTH  SIPO parallel output.
REQ-009 data_out  output  DATA_WIDTH  last good received word.
REQ-010 data_valid  output  1  one-cycle pulse when data_out updates.
REQ-011 frame_err  output  1  one-cycle pulse on bad stop bit.
REQ-012 busy  output  1  high whenever state != IDLE.

Function
REQ-013 rx SHALL pass through a 2-flop synchronizer (rx_s) before any use; both flops reset to 1.
REQ-014 The FSM SHALL have states IDLE, START, DATA, STOP, WAIT_IDLE, plus a cycle counter (0..CLKS_PER_BIT-1) and a bit index (0..DATA_WIDTH-1).
REQ-015 IDLE: rx_s=0 -> START, counter cleared.
REQ-016 START: when counter reaches CLKS_PER_BIT/2-1 (integer division), rx_s=0 -> DATA with counter and bit index cleared; rx_s=1 -> IDLE (glitch), no output activity.
REQ-017 DATA: when counter reaches CLKS_PER_BIT-1, shift_en=1 for exactly that cycle with serial_out=rx_s, and the counter wraps to 0.
REQ-018 DATA: the bit index SHALL increment on each shift_en; the pulse at index DATA_WIDTH-1 SHALL transition to STOP.
REQ-019 Bits SHALL be forwarded in received order (LSB first on the line); the controller performs no reordering.
REQ-020 STOP: when counter reaches CLKS_PER_BIT-1, rx_s=1 -> data_out<=parallel_in, data_valid=1 next cycle, go IDLE.
REQ-021 STOP: rx_s=0 at the stop sample point -> frame_err=1 next cycle, data_out unchanged, go WAIT_IDLE.
REQ-022 WAIT_IDLE: remain until rx_s=1, then IDLE; a held-low line (break) SHALL NOT be treated as a new start bit.
REQ-023 shift_en SHALL never assert outside DATA; data_valid and frame_err SHALL be mutually exclusive and never both high.
REQ-024 A falling edge on rx_s in IDLE during the same cycle the FSM returns from STOP SHALL be detected on the next cycle, so back-to-back frames with zero idle gap after the stop bit are received.
REQ-025 rx changes during START/DATA/STOP between sample points SHALL be ignored.
REQ-026 serial_out SHALL hold its last sampled value between shift_en pulses.

Reset
REQ-027 reset=1 SHALL immediately force state=IDLE, counter=0, bit index=0, shift_en=0, serial_out=0, data_out=0, data_valid=0, frame_err=0, busy=0, synchronizer=1.
REQ-028 reset mid-frame SHALL discard the partial frame with no data_valid or frame_err; reception resumes with the first start bit after reset release.

Verification (DATA_WIDTH=8, CLKS_PER_BIT=16; bench SIPO model shifts right, new bit into MSB)
REQ-029 Frame 0xA5, stop=1 -> 8 shift_en pulses 16 cycles apart, serial_out 1,0,1,0,0,1,0,1, one data_valid, data_out=0xA5, frame_err=0.
REQ-030 rx low 4 cycles then high from idle -> no shift_en, busy falls back to 0, no data_valid.
REQ-031 Frame 0x3C with stop=0, line held low 40 cycles -> one frame_err, no data_valid, data_out stays 0xA5, busy=1 until rx_s high, no spurious start.
REQ-032 Back-to-back 0x00 then 0xFF, second start bit immediately after first stop bit -> two data_valid pulses, data_out 0x00 then 0xFF.
REQ-033 reset asserted after 3rd data shift_en -> all outputs at REQ-027 values in the same cycle; following frame 0x5A -> data_valid with data_out=0x5A.

Source files
------------

// File: rtl/uart_rx_ctrl.sv
// uart_rx_ctrl: UART receive controller that samples the line and feeds an external SIPO register
module uart_rx_ctrl #(
    parameter int DATA_WIDTH   = 8,
    parameter int CLKS_PER_BIT = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  rx,
    output logic                  shift_en,
    output logic                  serial_out,
    input  logic [DATA_WIDTH-1:0] parallel_in,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  data_valid,
    output logic                  frame_err,
    output logic                  busy
);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int IW = $clog2(DATA_WIDTH);
    localparam logic [2:0] IDLE      = 3'd0;
    localparam logic [2:0] START     = 3'd1;
    localparam logic [2:0] DATA      = 3'd2;
    localparam logic [2:0] STOP      = 3'd3;
    localparam logic [2:0] WAIT_IDLE = 3'd4;
    localparam logic [CW-1:0] HALF     = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(DATA_WIDTH - 1);

    logic          rx_m, rx_s;
    logic [2:0]    state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [IW-1:0] idx, idx_n;
    logic          last_bit;
    logic          half_hit, bit_hit;
    logic          valid_n, err_n;

    assign half_hit   = cnt == HALF;
    assign bit_hit    = cnt == LAST;
    assign busy       = state != IDLE;
    assign shift_en   = (state == DATA) && bit_hit;
    assign serial_out = shift_en ? rx_s : last_bit;
    assign valid_n    = (state == STOP) && bit_hit && rx_s;
    assign err_n      = (state == STOP) && bit_hit && !rx_s;

    // two-flop synchronizer on the asynchronous line, idle-high out of reset
    always_ff @(posedge clk or posedge reset)
        if (reset) {rx_m, rx_s} <= 2'b11;
        else {rx_m, rx_s} <= {rx, rx_m};

    // next-state, sample counter and bit index; samples land mid-bit after the half-bit start check
    always_comb begin
        state_n = state;
        cnt_n   = cnt + CW'(1);
        idx_n   = idx;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (!rx_s) state_n = START;
            end
            START:
                if (half_hit) begin
                    cnt_n   = '0;
                    idx_n   = '0;
                    state_n = rx_s ? IDLE : DATA;
                end
            DATA:
                if (bit_hit) begin
                    cnt_n = '0;
                    idx_n = idx + IW'(1);
                    if (idx == LAST_IDX) begin
                        idx_n   = '0;
                        state_n = STOP;
                    end
                end
            STOP:
                if (bit_hit) begin
                    cnt_n   = '0;
                    state_n = rx_s ? IDLE : WAIT_IDLE;
                end
            WAIT_IDLE: begin
                cnt_n = '0;
                if (rx_s) state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
                idx_n   = '0;
            end
        endcase
    end

    // FSM state, counter and index registers
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            state <= IDLE;
            cnt   <= '0;
            idx   <= '0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            idx   <= idx_n;
        end

    // result capture: word latch, status pulses, and held copy of the last sampled bit
    always_ff @(posedge clk or posedge reset)
        if (reset) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            frame_err  <= 1'b0;
            last_bit   <= 1'b0;
        end else begin
            data_valid <= valid_n;
            frame_err  <= err_n;
            if (valid_n) data_out <= parallel_in;
            if (shift_en) last_bit <= rx_s;
        end
endmodule

// File: tb/tb_uart_rx_ctrl.sv
// tb_uart_rx_ctrl: scoreboard bench for uart_rx_ctrl with a right-shifting SIPO model
module tb_uart_rx_ctrl;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       rx = 1'b1;
    logic       shift_en, serial_out, data_valid, frame_err, busy;
    logic [7:0] parallel_in, data_out, sipo;
    int         checks = 0, failures = 0, cyc = 0, n_err = 0, n_both = 0;
    logic       exp_bits[$], obs_bits[$];
    logic [7:0] exp_words[$], obs_words[$];
    int         obs_cyc[$];

    uart_rx_ctrl #(.DATA_WIDTH(8), .CLKS_PER_BIT(16)) dut (
        .clk(clk), .reset(reset), .rx(rx), .shift_en(shift_en), .serial_out(serial_out),
        .parallel_in(parallel_in), .data_out(data_out), .data_valid(data_valid),
        .frame_err(frame_err), .busy(busy)
    );

    always #5 clk = ~clk;

    assign parallel_in = sipo;

    // external SIPO: shifts right, new bit enters at the MSB
    always_ff @(posedge clk or posedge reset)
        if (reset) sipo <= '0;
        else if (shift_en) sipo <= {serial_out, sipo[7:1]};

    // monitor: log DUT output events away from the active edge
    always @(negedge clk) begin
        cyc++;
        if (shift_en) begin
            obs_bits.push_back(serial_out);
            obs_cyc.push_back(cyc);
        end
        if (data_valid) obs_words.push_back(data_out);
        if (frame_err) n_err++;
        if (data_valid && frame_err) n_both++;
    end

    task automatic send_bit(input logic b);
        rx = b;
        repeat (16) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] w, input logic stop);
        for (int i = 0; i < 8; i++) exp_bits.push_back(w[i]);
        if (stop) exp_words.push_back(w);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(w[i]);
        send_bit(stop);
        rx = 1'b1;
    endtask

    task automatic test_reset();
        #1 reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if ({shift_en, serial_out, data_valid, frame_err, busy} !== 5'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=00000", {shift_en, serial_out, data_valid, frame_err, busy});
        end
        checks++;
        if (data_out !== 8'h00) begin
            failures++;
            $display("FAIL reset_data got=%h exp=00", data_out);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        checks++;
        if (busy !== 1'b0) begin
            failures++;
            $display("FAIL reset_idle_busy got=%b exp=0", busy);
        end
    endtask

    task automatic test_frame_a5();
        logic e, o;
        int e0;
        e0 = n_err;
        send_frame(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (obs_bits.size() != 8) begin
            failures++;
            $display("FAIL a5_shift_count got=%0d exp=8", obs_bits.size());
        end
        for (int i = 1; i < obs_cyc.size(); i++) begin
            checks++;
            if (obs_cyc[i] - obs_cyc[i-1] != 16) begin
                failures++;
                $display("FAIL a5_shift_spacing idx=%0d got=%0d exp=16", i, obs_cyc[i] - obs_cyc[i-1]);
            end
        end
        while (exp_bits.size() > 0 && obs_bits.size() > 0) begin
            e = exp_bits.pop_front();
            o = obs_bits.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL a5_serial_out got=%b exp=%b", o, e);
            end
        end
        checks++;
        if (obs_words.size() != 1 || obs_words[0] !== exp_words[0]) begin
            failures++;
            $display("FAIL a5_data_valid count=%0d exp_count=1", obs_words.size());
        end
        checks++;
        if (data_out !== 8'hA5 || n_err != e0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL a5_final data_out=%h err=%0d busy=%b exp=a5/0/0", data_out, n_err - e0, busy);
        end
        exp_bits.delete(); exp_words.delete(); obs_bits.delete(); obs_words.delete(); obs_cyc.delete();
    endtask

    task automatic test_glitch();
        logic saw_busy;
        saw_busy = 1'b0;
        rx = 1'b0;
        repeat (4) @(negedge clk);
        rx = 1'b1;
        repeat (30) begin
            @(negedge clk);
            if (busy) saw_busy = 1'b1;
        end
        #1;
        checks++;
        if (saw_busy !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL glitch_busy saw=%b now=%b exp=1/0", saw_busy, busy);
        end
        checks++;
        if (obs_bits.size() != 0 || obs_words.size() != 0) begin
            failures++;
            $display("FAIL glitch_activity shifts=%0d words=%0d exp=0/0", obs_bits.size(), obs_words.size());
        end
    endtask

    task automatic test_frame_err();
        logic e, o, held_busy;
        int e0;
        e0 = n_err;
        held_busy = 1'b1;
        send_frame(8'h3C, 1'b0);
        rx = 1'b0;
        repeat (40) begin
            @(negedge clk);
            if (!busy) held_busy = 1'b0;
        end
        checks++;
        if (held_busy !== 1'b1) begin
            failures++;
            $display("FAIL ferr_busy_hold got=0 exp=1");
        end
        rx = 1'b1;
        repeat (30) @(negedge clk);
        #1;
        checks++;
        if (n_err - e0 != 1 || obs_words.size() != 0) begin
            failures++;
            $display("FAIL ferr_pulses err=%0d valid=%0d exp=1/0", n_err - e0, obs_words.size());
        end
        checks++;
        if (data_out !== 8'hA5 || busy !== 1'b0 || obs_bits.size() != 8) begin
            failures++;
            $display("FAIL ferr_final data_out=%h busy=%b shifts=%0d exp=a5/0/8", data_out, busy, obs_bits.size());
        end
        while (exp_bits.size() > 0 && obs_bits.size() > 0) begin
            e = exp_bits.pop_front();
            o = obs_bits.pop_front();
            checks++;
            if (o !== e) begin
                failures++;
                $display("FAIL ferr_serial_out got=%b exp=%b", o, e);
            end
        end
        exp_bits.delete(); exp_words.delete(); obs_bits.delete(); obs_words.delete(); obs_cyc.delete();
    endtask

    task automatic test_back_to_back();
        logic [7:0] ew, ow;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (obs_bits.size() != 16 || obs_words.size() != 2) begin
            failures++;
            $display("FAIL b2b_counts shifts=%0d words=%0d exp=16/2", obs_bits.size(), obs_words.size());
        end
        while (exp_words.size() > 0 && obs_words.size() > 0) begin
            ew = exp_words.pop_front();
            ow = obs_words.pop_front();
            checks++;
            if (ow !== ew) begin
                failures++;
                $display("FAIL b2b_data_out got=%h exp=%h", ow, ew);
            end
        end
        exp_bits.delete(); exp_words.delete(); obs_bits.delete(); obs_words.delete(); obs_cyc.delete();
    endtask

    task automatic test_reset_mid();
        int e0;
        e0 = n_err;
        send_bit(1'b0);
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        repeat (2) @(negedge clk);
        checks++;
        if (obs_bits.size() != 3) begin
            failures++;
            $display("FAIL rmid_pre_shifts got=%0d exp=3", obs_bits.size());
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({shift_en, serial_out, data_valid, frame_err, busy} !== 5'b0 || data_out !== 8'h00) begin
            failures++;
            $display("FAIL rmid_reset_outputs flags=%b data_out=%h exp=00000/00",
                     {shift_en, serial_out, data_valid, frame_err, busy}, data_out);
        end
        repeat (3) @(negedge clk);
        reset = 1'b0;
        rx = 1'b1;
        obs_bits.delete(); obs_cyc.delete();
        repeat (20) @(negedge clk);
        send_frame(8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        #1;
        checks++;
        if (obs_words.size() != 1 || data_out !== 8'h5A || n_err != e0) begin
            failures++;
            $display("FAIL rmid_next_frame words=%0d data_out=%h err=%0d exp=1/5a/0", obs_words.size(), data_out, n_err - e0);
        end
        checks++;
        if (obs_bits.size() != 8) begin
            failures++;
            $display("FAIL rmid_shift_count got=%0d exp=8", obs_bits.size());
        end
        exp_bits.delete(); exp_words.delete(); obs_bits.delete(); obs_words.delete(); obs_cyc.delete();
    endtask

    initial begin
        test_reset();
        test_frame_a5();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_reset_mid();
        checks++;
        if (n_both != 0) begin
            failures++;
            $display("FAIL valid_err_exclusive got=%0d exp=0", n_both);
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
